adc_spi_mux_controller: RTL

//  Multi-channel SPI ADC controller; successor to the fixed-width single-channel controller.

---
 rtl/adc_spi_mux_controller.sv | 220 ++++++++++++++++++++++
 1 files changed

// File: rtl/adc_spi_mux_controller.sv
// Multi-channel SPI ADC controller: trigger + channel in, framed SPI transfer, tagged sample out.
// Optional auto-trigger with round-robin channel selection when ADC_AUTO_TRIG_EN is defined.
module adc_spi_mux_controller #(
    parameter int unsigned DATA_W      = 12,
    parameter int unsigned FRAME_W     = 16,
    parameter int unsigned CH_NUM      = 8,
    parameter int unsigned CH_W        = 3,
    parameter int unsigned ADDR_POS    = 2,
    parameter int unsigned CLK_DIV     = 2,
    parameter int unsigned CS_SETUP    = 2,
    parameter int unsigned CS_GAP      = 2,
    parameter int unsigned AUTO_PERIOD = 100
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              adc_trig,
    input  logic [CH_W-1:0]   adc_ch,
`ifdef ADC_AUTO_TRIG_EN
    input  logic              adc_auto,
`endif
    output logic              adc_busy,
    output logic              adc_dval,
    output logic [DATA_W-1:0] adc_data,
    output logic [CH_W-1:0]   adc_data_ch,
    output logic              adc_err,
    output logic              adc_csn,
    output logic              adc_sclk,
    output logic              adc_sdi,
    input  logic              adc_sdo
);

    localparam int unsigned CNT_MAX0 = (CS_SETUP > 2 * CLK_DIV) ? CS_SETUP : 2 * CLK_DIV;
    localparam int unsigned CNT_MAX  = (CS_GAP > CNT_MAX0) ? CS_GAP : CNT_MAX0;
    localparam int unsigned CNT_W    = $clog2(CNT_MAX);
    localparam int unsigned BIT_W    = (FRAME_W > 1) ? $clog2(FRAME_W) : 1;

    if (DATA_W < 1 || FRAME_W < DATA_W || CH_NUM < 1 || CH_NUM > (1 << CH_W) ||
        ADDR_POS + CH_W > FRAME_W || CLK_DIV < 1 || CS_SETUP < 1 || CS_GAP < 1 ||
        AUTO_PERIOD < 1) begin : g_param_err
        $error("adc_spi_mux_controller: illegal parameter combination");
    end

    typedef enum logic [1:0] {StIdle, StSetup, StShift, StGap} state_e;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [BIT_W-1:0]    bit_q, bit_d;
    logic [CH_W-1:0]     ch_q, ch_d;
    logic [DATA_W-1:0]   shreg_q, shreg_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic [CH_W-1:0]     data_ch_q, data_ch_d;
    logic                csn_q, csn_d;
    logic                sclk_q, sclk_d;
    logic                sdi_q, sdi_d;
    logic                dval_q, dval_d;
    logic                err_q, err_d;
    logic                trig_eff;
    logic [CH_W-1:0]     ch_eff;
    logic                ch_ok;

    // Channel address occupies frame bits ADDR_POS..ADDR_POS+CH_W-1, MSB first; all else is 0.
    function automatic logic frame_bit(input logic [BIT_W-1:0] idx, input logic [CH_W-1:0] ch);
        logic b;
        b = 1'b0;
        for (int k = 0; k < int'(CH_W); k++) begin
            if (32'(idx) == ADDR_POS + 32'(k)) b = ch[CH_W-1-k];
        end
        return b;
    endfunction

`ifdef ADC_AUTO_TRIG_EN
    localparam int unsigned AP_W = (AUTO_PERIOD > 1) ? $clog2(AUTO_PERIOD) : 1;

    logic [AP_W-1:0] auto_cnt_q, auto_cnt_d;
    logic [CH_W-1:0] rr_q, rr_d;

    // Counters are held at zero while auto mode is off, so a rising adc_auto restarts both.
    assign trig_eff = adc_auto ? (auto_cnt_q == '0) : adc_trig;
    assign ch_eff   = adc_auto ? rr_q : adc_ch;

    always_comb begin
        auto_cnt_d = '0;
        rr_d       = '0;
        if (adc_auto) begin
            auto_cnt_d = (auto_cnt_q == AP_W'(AUTO_PERIOD - 1)) ? '0 : auto_cnt_q + 1'b1;
            rr_d       = rr_q;
            if (trig_eff && state_q == StIdle) begin
                rr_d = (rr_q == CH_W'(CH_NUM - 1)) ? '0 : rr_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            auto_cnt_q <= '0;
            rr_q       <= '0;
        end else begin
            auto_cnt_q <= auto_cnt_d;
            rr_q       <= rr_d;
        end
    end
`else
    assign trig_eff = adc_trig;
    assign ch_eff   = adc_ch;
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_d     = bit_q;
        ch_d      = ch_q;
        shreg_d   = shreg_q;
        data_d    = data_q;
        data_ch_d = data_ch_q;
        csn_d     = csn_q;
        sclk_d    = sclk_q;
        sdi_d     = sdi_q;
        dval_d    = 1'b0;
        err_d     = 1'b0;
        ch_ok     = ({1'b0, ch_eff} < (CH_W + 1)'(CH_NUM));

        if (trig_eff && (state_q != StIdle || !ch_ok)) err_d = 1'b1;

        unique case (state_q)
            StIdle: begin
                if (trig_eff && ch_ok) begin
                    state_d = StSetup;
                    ch_d    = ch_eff;
                    cnt_d   = '0;
                    csn_d   = 1'b0;
                end
            end
            StSetup: begin
                if (cnt_q == CNT_W'(CS_SETUP - 1)) begin
                    state_d = StShift;
                    cnt_d   = '0;
                    bit_d   = '0;
                    sclk_d  = 1'b0;
                    sdi_d   = frame_bit('0, ch_q);
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StShift: begin
                cnt_d = cnt_q + 1'b1;
                // End of low half: SCLK rises here, so this is the SDO sample point.
                if (cnt_q == CNT_W'(CLK_DIV - 1)) begin
                    sclk_d = 1'b1;
                    if (32'(bit_q) >= FRAME_W - DATA_W) begin
                        shreg_d = (shreg_q << 1) | DATA_W'(adc_sdo);
                    end
                end
                if (cnt_q == CNT_W'(2 * CLK_DIV - 1)) begin
                    cnt_d = '0;
                    if (bit_q == BIT_W'(FRAME_W - 1)) begin
                        state_d   = StGap;
                        csn_d     = 1'b1;
                        sdi_d     = 1'b0;
                        dval_d    = 1'b1;
                        data_d    = shreg_q;
                        data_ch_d = ch_q;
                    end else begin
                        bit_d  = bit_q + 1'b1;
                        sclk_d = 1'b0;
                        sdi_d  = frame_bit(bit_q + 1'b1, ch_q);
                    end
                end
            end
            StGap: begin
                if (cnt_q == CNT_W'(CS_GAP - 1)) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            bit_q     <= '0;
            ch_q      <= '0;
            shreg_q   <= '0;
            data_q    <= '0;
            data_ch_q <= '0;
            csn_q     <= 1'b1;
            sclk_q    <= 1'b1;
            sdi_q     <= 1'b0;
            dval_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            ch_q      <= ch_d;
            shreg_q   <= shreg_d;
            data_q    <= data_d;
            data_ch_q <= data_ch_d;
            csn_q     <= csn_d;
            sclk_q    <= sclk_d;
            sdi_q     <= sdi_d;
            dval_q    <= dval_d;
            err_q     <= err_d;
        end
    end

    assign adc_busy    = (state_q != StIdle);
    assign adc_dval    = dval_q;
    assign adc_data    = data_q;
    assign adc_data_ch = data_ch_q;
    assign adc_err     = err_q;
    assign adc_csn     = csn_q;
    assign adc_sclk    = sclk_q;
    assign adc_sdi     = sdi_q;

endmodule
